load_store_unit: RTL and testbench

Multi-cycle data-memory access unit for the turtle CPU, sitting between the register file and the data-memory port. On a start pulse it forms the address {DBAR, DOFF}, performs one load or store over a req/ready handshake, and writes results back to the register file. Loads write ACC plus the Z/N status flags. The optional post-increment writes back DOFF, and DBAR on carry. Control sequencing pulses `start_i` and waits for `done_o`.

---
 rtl/load_store_unit.sv | 206 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access unit: one load or store at {DBAR, DOFF} over a
// req/ready handshake, then register-file write-back of ACC/flags and the post-incremented address.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  op_store_i,
  input  logic                  post_inc_i,
  input  logic [DATA_WIDTH-1:0] dbar_i,
  input  logic [DATA_WIDTH-1:0] doff_i,
  input  logic [DATA_WIDTH-1:0] acc_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rf_we_o,
  output logic [3:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  flag_we_o,
  output logic                  flag_z_o,
  output logic                  flag_n_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WB_ACC  = 3'd2,
    S_WB_DOFF = 3'd3,
    S_WB_DBAR = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    REG_ACC  = 4'b1000,
    REG_DBAR = 4'b1001,
    REG_DOFF = 4'b1010
  } reg_addr_e;

  state_e state_q, state_d;

  logic                  store_q, store_d;
  logic                  inc_q, inc_d;
  logic [DATA_WIDTH-1:0] dbar_q, dbar_d;
  logic [DATA_WIDTH-1:0] doff_q, doff_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  busy_d, done_d, mem_req_d, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic                  rf_we_d;
  logic [3:0]            rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_d;
  logic                  flag_we_d, flag_z_d, flag_n_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_REQ;
      S_REQ: begin
        if (mem_ready_i) begin
          if (!store_q)   state_d = S_WB_ACC;
          else if (inc_q) state_d = S_WB_DOFF;
          else            state_d = S_DONE;
        end
      end
      S_WB_ACC:  state_d = inc_q ? S_WB_DOFF : S_DONE;
      S_WB_DOFF: state_d = (doff_q == '1) ? S_WB_DBAR : S_DONE;
      S_WB_DBAR: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Operand latch on accepted start; read data captured on the ready cycle
  always_comb begin
    store_d = store_q;
    inc_d   = inc_q;
    dbar_d  = dbar_q;
    doff_d  = doff_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          store_d = op_store_i;
          inc_d   = post_inc_i;
          dbar_d  = dbar_i;
          doff_d  = doff_i;
          acc_d   = acc_i;
          rdata_d = '0;
        end
      end
      S_REQ:   if (mem_ready_i && !store_q) rdata_d = mem_rdata_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      store_q <= 1'b0;
      inc_q   <= 1'b0;
      dbar_q  <= '0;
      doff_q  <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
    end else begin
      store_q <= store_d;
      inc_q   <= inc_d;
      dbar_q  <= dbar_d;
      doff_q  <= doff_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    busy_d      = 1'b0;
    done_d      = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    rf_we_d     = 1'b0;
    rf_waddr_d  = 4'b0000;
    rf_wdata_d  = '0;
    flag_we_d   = 1'b0;
    flag_z_d    = 1'b0;
    flag_n_d    = 1'b0;
    busy_d      = (state_d != S_IDLE);
    case (state_d)
      S_REQ: begin
        mem_req_d   = 1'b1;
        mem_we_d    = store_d;
        mem_addr_d  = ADDR_WIDTH'({dbar_d, doff_d});
        mem_wdata_d = store_d ? acc_d : '0;
      end
      S_WB_ACC: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = 4'(REG_ACC);
        rf_wdata_d = rdata_d;
        flag_we_d  = 1'b1;
        flag_z_d   = (rdata_d == '0);
        flag_n_d   = rdata_d[DATA_WIDTH-1];
      end
      S_WB_DOFF: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = 4'(REG_DOFF);
        rf_wdata_d = DATA_WIDTH'(doff_d + 1'b1);
      end
      S_WB_DBAR: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = 4'(REG_DBAR);
        rf_wdata_d = DATA_WIDTH'(dbar_d + 1'b1);
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rf_we_o     <= 1'b0;
      rf_waddr_o  <= 4'b0000;
      rf_wdata_o  <= '0;
      flag_we_o   <= 1'b0;
      flag_z_o    <= 1'b0;
      flag_n_o    <= 1'b0;
    end else begin
      busy_o      <= busy_d;
      done_o      <= done_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      rf_we_o     <= rf_we_d;
      rf_waddr_o  <= rf_waddr_d;
      rf_wdata_o  <= rf_wdata_d;
      flag_we_o   <= flag_we_d;
      flag_z_o    <= flag_z_d;
      flag_n_o    <= flag_n_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single accesses plus
// hand sequences for start-while-busy, start-in-DONE and reset mid-handshake.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, op_store_i, post_inc_i;
  logic [7:0]  dbar_i, doff_i, acc_i;
  logic        busy_o, done_o, mem_req_o, mem_we_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_ready_i;
  logic [7:0]  mem_rdata_i;
  logic        rf_we_o;
  logic [3:0]  rf_waddr_o;
  logic [7:0]  rf_wdata_o;
  logic        flag_we_o, flag_z_o, flag_n_o;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_store_i(op_store_i),
    .post_inc_i(post_inc_i), .dbar_i(dbar_i), .doff_i(doff_i), .acc_i(acc_i),
    .busy_o(busy_o), .done_o(done_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .flag_we_o(flag_we_o), .flag_z_o(flag_z_o),
    .flag_n_o(flag_n_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        inc;
    logic [7:0]  dbar;
    logic [7:0]  doff;
    logic [7:0]  acc;
    int          wait_n;
    logic [7:0]  rdata;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    int          e_done;
    int          e_nwr;
    logic [3:0]  e_wa0, e_wa1, e_wa2;
    logic [7:0]  e_wd0, e_wd1, e_wd2;
    logic        e_z;
    logic        e_n;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] any_out();
    return 32'(|{busy_o, done_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
                 rf_we_o, rf_waddr_o, rf_wdata_o, flag_we_o, flag_z_o, flag_n_o});
  endfunction

  task automatic add(input logic st, input logic inc, input logic [7:0] dbar,
                     input logic [7:0] doff, input logic [7:0] acc, input int wait_n,
                     input logic [7:0] rdata, input logic [15:0] e_addr,
                     input logic [7:0] e_wdata, input int e_done, input int e_nwr,
                     input logic [3:0] wa0, input logic [7:0] wd0,
                     input logic [3:0] wa1, input logic [7:0] wd1,
                     input logic [3:0] wa2, input logic [7:0] wd2,
                     input logic e_z, input logic e_n);
    vec_t v;
    v.st = st; v.inc = inc; v.dbar = dbar; v.doff = doff; v.acc = acc;
    v.wait_n = wait_n; v.rdata = rdata; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_done = e_done; v.e_nwr = e_nwr;
    v.e_wa0 = wa0; v.e_wd0 = wd0; v.e_wa1 = wa1; v.e_wd1 = wd1;
    v.e_wa2 = wa2; v.e_wd2 = wd2; v.e_z = e_z; v.e_n = e_n;
    vecs.push_back(v);
  endtask

  // One access from start pulse (cycle 0) to done; returns at the done cycle's negedge
  task automatic run_txn(input vec_t v, input string tag);
    int         req_cnt = 0;
    int         nwr = 0;
    int         done_cyc = -1;
    logic [3:0] wa[3];
    logic [7:0] wd[3];
    logic [3:0] ewa[3];
    logic [7:0] ewd[3];
    logic       z = 1'b0;
    logic       n = 1'b0;
    for (int i = 0; i < 3; i++) begin wa[i] = 4'hF; wd[i] = 8'hEE; end
    ewa[0] = v.e_wa0; ewa[1] = v.e_wa1; ewa[2] = v.e_wa2;
    ewd[0] = v.e_wd0; ewd[1] = v.e_wd1; ewd[2] = v.e_wd2;
    @(posedge clk); #1;
    start_i = 1'b1; op_store_i = v.st; post_inc_i = v.inc;
    dbar_i = v.dbar; doff_i = v.doff; acc_i = v.acc;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0; op_store_i = ~v.st; post_inc_i = ~v.inc;
      dbar_i = ~v.dbar; doff_i = ~v.doff; acc_i = ~v.acc;
      mem_ready_i = mem_req_o && (req_cnt == v.wait_n);
      mem_rdata_i = mem_ready_i ? v.rdata : 8'hEE;
      @(negedge clk);
      if (mem_req_o) begin
        req_cnt++;
        chk({tag, " mem_addr"}, 32'(mem_addr_o), 32'(v.e_addr));
        chk({tag, " mem_we"}, 32'(mem_we_o), 32'(v.st));
        chk({tag, " mem_wdata"}, 32'(mem_wdata_o), 32'(v.e_wdata));
      end
      chk({tag, " flag_we"}, 32'(flag_we_o), 32'(rf_we_o && rf_waddr_o == 4'b1000));
      if (rf_we_o) begin
        if (nwr < 3) begin wa[nwr] = rf_waddr_o; wd[nwr] = rf_wdata_o; end
        nwr++;
        if (rf_waddr_o == 4'b1000) begin z = flag_z_o; n = flag_n_o; end
      end
      if (done_o) begin
        done_cyc = c;
        chk({tag, " busy_at_done"}, 32'(busy_o), 32'd1);
      end
    end
    mem_ready_i = 1'b0;
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'(v.e_done));
    chk({tag, " req_cycles"}, 32'(req_cnt), 32'(v.wait_n + 1));
    chk({tag, " rf_writes"}, 32'(nwr), 32'(v.e_nwr));
    for (int i = 0; i < v.e_nwr && i < 3; i++) begin
      chk($sformatf("%s wr%0d_addr", tag, i), 32'(wa[i]), 32'(ewa[i]));
      chk($sformatf("%s wr%0d_data", tag, i), 32'(wd[i]), 32'(ewd[i]));
    end
    if (!v.st) begin
      chk({tag, " flag_z"}, 32'(z), 32'(v.e_z));
      chk({tag, " flag_n"}, 32'(n), 32'(v.e_n));
    end
  endtask

  initial begin
    vec_t fresh;
    rst_n = 1'b0; start_i = 1'b0; op_store_i = 1'b0; post_inc_i = 1'b0;
    dbar_i = '0; doff_i = '0; acc_i = '0; mem_ready_i = 1'b0; mem_rdata_i = '0;

    //  st inc dbar   doff   acc    w  rdata  addr      wdata  done nwr  wr0          wr1          wr2          z     n
    add(1, 0, 8'h12, 8'h34, 8'hA5, 0, 8'h00, 16'h1234, 8'hA5, 2, 0, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 8'h10, 8'h5A, 3, 8'h80, 16'h0010, 8'h00, 6, 1, 4'h8, 8'h80, 4'h0, 8'h00, 4'h0, 8'h00, 0, 1);
    add(0, 1, 8'h20, 8'h07, 8'h33, 0, 8'h00, 16'h2007, 8'h00, 4, 2, 4'h8, 8'h00, 4'hA, 8'h08, 4'h0, 8'h00, 1, 0);
    add(1, 1, 8'hFF, 8'hFF, 8'hC3, 0, 8'h00, 16'hFFFF, 8'hC3, 4, 2, 4'hA, 8'h00, 4'h9, 8'h00, 4'h0, 8'h00, 0, 0);
    add(0, 1, 8'h3C, 8'hFF, 8'h11, 1, 8'h7F, 16'h3CFF, 8'h00, 6, 3, 4'h8, 8'h7F, 4'hA, 8'h00, 4'h9, 8'h3D, 0, 0);
    add(1, 1, 8'h01, 8'hFE, 8'h00, 2, 8'h00, 16'h01FE, 8'h00, 5, 1, 4'hA, 8'hFF, 4'h0, 8'h00, 4'h0, 8'h00, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", any_out(), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle outputs", any_out(), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("vec%0d idle_after", i), 32'(busy_o), 32'd0);
    end

    // start raised during DONE must be ignored
    run_txn(vecs[0], "done_start");
    start_i = 1'b1; op_store_i = 1'b0; dbar_i = 8'h77; doff_i = 8'h66;
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    chk("done_start busy", 32'(busy_o), 32'd0);
    chk("done_start req", 32'(mem_req_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_start still_idle", 32'(busy_o), 32'd0);

    // start while busy is ignored, then reset aborts the pending request
    @(posedge clk); #1;
    start_i = 1'b1; op_store_i = 1'b0; post_inc_i = 1'b1;
    dbar_i = 8'h44; doff_i = 8'h55; acc_i = 8'h00;
    @(posedge clk); #1 start_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; op_store_i = 1'b1; dbar_i = 8'h99; doff_i = 8'h99; acc_i = 8'hAA;
    @(negedge clk);
    chk("busy_start addr", 32'(mem_addr_o), 32'h4455);
    chk("busy_start we", 32'(mem_we_o), 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("busy_start addr_held", 32'(mem_addr_o), 32'h4455);
    chk("busy_start req_held", 32'(mem_req_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_req_reset outs", any_out(), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset rf_we", 32'(rf_we_o), 32'd0);
    chk("after_reset outs", any_out(), 32'd0);

    fresh = vecs[0];
    fresh.dbar = 8'h01; fresh.doff = 8'h02; fresh.acc = 8'hAB;
    fresh.e_addr = 16'h0102; fresh.e_wdata = 8'hAB;
    run_txn(fresh, "fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
